// File: rtl/cp0_m.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, mfc0/mtc0/eret decode,
// interrupt/exception arbitration, flush and fetch redirect. Optional timer: CP0_COUNT_EN.
module cp0_m #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2017_1206
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrM,
  input  logic [31:0] pcM,
  input  logic        validM,
  input  logic        bdM,
  input  logic        excM,
  input  logic [4:0]  excCodeM,
  input  logic [31:0] rtDataM,
  input  logic [5:0]  hwint,
  output logic [31:0] cp0RdataM,
  output logic        DEMWclr,
  output logic        redirect,
  output logic [31:0] redirectPc
);
  logic [5:0]  r_im, r_ip;
  logic        r_exl, r_ie, r_bd;
  logic [4:0]  r_excCode;
  logic [31:0] r_epc;

  logic        w_cop0, w_mfc0, w_mtc0, w_eret;
  logic [4:0]  w_idx;
  logic        w_intReq, w_excTake, w_take, w_eretGo, w_wr;
  logic [5:0]  w_ipNext;

  assign w_cop0    = (instrM[31:26] == 6'b010000);
  assign w_mfc0    = w_cop0 && (instrM[25:21] == 5'b00000);
  assign w_mtc0    = w_cop0 && (instrM[25:21] == 5'b00100);
  assign w_eret    = (instrM == 32'h4200_0018);
  assign w_idx     = instrM[15:11];

  assign w_intReq  = (|(r_ip & r_im)) & r_ie & ~r_exl & validM;
  assign w_excTake = excM & validM & ~r_exl;
  assign w_take    = w_intReq | w_excTake;
  assign w_eretGo  = w_eret & validM & ~w_take;
  // A take suppresses the mtc0 in M so the exception's register writes win.
  assign w_wr      = w_mtc0 & validM & ~w_take;

  assign DEMWclr    = w_take | w_eretGo;
  assign redirect   = DEMWclr;
  assign redirectPc = w_eretGo ? r_epc : HANDLER_PC;

`ifdef CP0_COUNT_EN
  logic [31:0] r_count, r_compare;
  logic        r_timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_timer   <= 1'b0;
    end else begin
      r_count <= (w_wr && w_idx == 5'd9) ? rtDataM : r_count + 32'd1;
      if (w_wr && w_idx == 5'd11) begin
        r_compare <= rtDataM;
        r_timer   <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer <= 1'b1;
      end
    end
  end

  assign w_ipNext = hwint | {r_timer, 5'b0};
`else
  assign w_ipNext = hwint;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im      <= '0;
      r_ip      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_excCode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= w_ipNext;
      if (w_take) begin
        r_exl     <= 1'b1;
        r_excCode <= w_intReq ? 5'd0 : excCodeM;
        r_bd      <= bdM;
        r_epc     <= bdM ? pcM - 32'd4 : pcM;
      end else if (w_eretGo) begin
        r_exl <= 1'b0;
      end else if (w_wr) begin
        case (w_idx)
          5'd12: begin
            r_im  <= rtDataM[15:10];
            r_exl <= rtDataM[1];
            r_ie  <= rtDataM[0];
          end
          5'd14:   r_epc <= rtDataM;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0RdataM = '0;
    if (w_mfc0) begin
      case (w_idx)
        5'd12: cp0RdataM = {16'b0, r_im, 8'b0, r_exl, r_ie};
        5'd13: cp0RdataM = {r_bd, 15'b0, r_ip, 3'b0, r_excCode, 2'b0};
        5'd14: cp0RdataM = r_epc;
        5'd15: cp0RdataM = PRID;
`ifdef CP0_COUNT_EN
        5'd9:  cp0RdataM = r_count;
        5'd11: cp0RdataM = r_compare;
`endif
        default: cp0RdataM = '0;
      endcase
    end
  end
endmodule
